// File: rtl/sub_seq_ctrl.sv
// ---------------------------------------------------------------------------
// sub_seq_ctrl
// Sequential unsigned subtractor. It computes diff = a - b mod 2^W one 4-bit
// slice per clock, least-significant slice first, and ripples the borrow
// between slices through a borrow register.
//
// Ports
//   clk   : single clock, rising-edge active
//   rst   : asynchronous active-high reset
//   start : begin a subtraction (sampled only while idle)
//   a, b  : minuend / subtrahend, W = 4*NIBBLES bits, latched on acceptance
//   busy  : high while an operation is running or completing
//   done  : one-cycle pulse, diff/Bout valid
//   diff  : registered result, held until the next operation completes
//   Bout  : final borrow (1 when a < b, unsigned)
// ---------------------------------------------------------------------------
module sub_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] diff,
    output logic                 Bout
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t           state_q;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     work_q;
    logic             borrow_q;
    logic [IDX_W-1:0] idx_q;
    logic             busy_q;
    logic             done_q;
    logic [W-1:0]     diff_q;
    logic             bout_q;

    logic [IDX_W+1:0] sh_s;
    logic [3:0]       a_slice_s;
    logic [3:0]       b_slice_s;
    logic [4:0]       sub_s;
    logic [W-1:0]     mask_s;
    logic [W-1:0]     work_d;
    logic             borrow_d;

    // Slice subtraction for the current index and the merged working result.
    always_comb begin
        sh_s      = {idx_q, 2'b00};
        a_slice_s = a_q[sh_s +: 4];
        b_slice_s = b_q[sh_s +: 4];
        // 5-bit intermediate: bit 4 is set exactly when a_i < b_i + borrow.
        sub_s     = {1'b0, a_slice_s} - {1'b0, b_slice_s} - {4'b0000, borrow_q};
        mask_s    = W'(4'hF) << sh_s;
        work_d    = (work_q & ~mask_s) | (W'(sub_s[3:0]) << sh_s);
        borrow_d  = sub_s[4];
    end

    // Control FSM with all datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            work_q   <= '0;
            borrow_q <= 1'b0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        work_q   <= '0;
                        borrow_q <= 1'b0;
                        idx_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_RUN;
                    end else begin
                        state_q  <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    work_q   <= work_d;
                    borrow_q <= borrow_d;
                    if (idx_q == LAST_IDX) begin
                        // Publish only the complete result so diff never shows partials.
                        diff_q  <= work_d;
                        bout_q  <= borrow_d;
                        done_q  <= 1'b1;
                        idx_q   <= '0;
                        state_q <= ST_DONE;
                    end else begin
                        idx_q   <= idx_q + IDX_W'(1);
                        state_q <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    idx_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign Bout = bout_q;

endmodule

// File: tb/tb_sub_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sub_seq_ctrl
// Directed bench for sub_seq_ctrl. A transaction-level model (accept, count
// down the fixed latency, publish a - b) predicts every output each cycle and
// a compare process checks it on the falling edge. Directed scenarios add
// hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_sub_seq_ctrl;

    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         Bout;

    int pass_cnt  = 0;
    int total_cnt = 0;

    sub_seq_ctrl #(.NIBBLES(NIB)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .Bout  (Bout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic         m_busy, m_done, m_bout, m_pbout;
    logic [W-1:0] m_diff, m_pend;
    int           m_left;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_diff <= '0;
            m_bout <= 1'b0;
            m_left <= 0;
        end else if (!m_busy) begin
            m_done <= 1'b0;
            if (start) begin
                m_busy  <= 1'b1;
                m_left  <= NIB + 1;
                m_pend  <= a - b;
                m_pbout <= (a < b);
            end
        end else begin
            m_left <= m_left - 1;
            if (m_left == 2) begin
                m_done <= 1'b1;
                m_diff <= m_pend;
                m_bout <= m_pbout;
            end else begin
                m_done <= 1'b0;
            end
            if (m_left == 1) m_busy <= 1'b0;
        end
    end

    // Compare process: every falling edge once reset has been applied.
    logic cmp_en = 1'b0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_busy", {31'd0, busy}, {31'd0, m_busy});
            chk("model_done", {31'd0, done}, {31'd0, m_done});
            chk("model_diff", {16'd0, diff}, {16'd0, m_diff});
            chk("model_bout", {31'd0, Bout}, {31'd0, m_bout});
        end
    end

    // One operation: accept, measure latency, check the literal result.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] ed, input logic eb, input string nm);
        int cyc;
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done && cyc <= 20);
        chk({nm, "_latency"}, cyc, NIB + 1);
        chk({nm, "_diff"}, {16'd0, diff}, {16'd0, ed});
        chk({nm, "_bout"}, {31'd0, Bout}, {31'd0, eb});
        @(negedge clk);
    endtask

    int ndone;
    int last_done;
    logic [W-1:0] cap_diff;

    initial begin
        #1 rst = 1'b1;
        @(negedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_diff", {16'd0, diff}, 32'd0);
        chk("reset_bout", {31'd0, Bout}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(16'h0007, 16'h0003, 16'h0004, 1'b0, "basic");
        run_op(16'h1000, 16'h0001, 16'h0FFF, 1'b0, "ripple");
        run_op(16'h0000, 16'h0001, 16'hFFFF, 1'b1, "underflow");
        run_op(16'hA5A5, 16'hA5A5, 16'h0000, 1'b0, "equal");
        run_op(16'h1234, 16'h4321, 16'hCF13, 1'b1, "mixed");

        // Start pulsed during RUN must be dropped.
        a = 16'h0050;
        b = 16'h0010;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        a = 16'hFFFF;
        b = 16'h0000;
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        cap_diff = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                cap_diff = diff;
            end
        end
        chk("ignore_start_ndone", ndone, 32'd1);
        chk("ignore_start_diff", {16'd0, cap_diff}, 32'h0040);

        // Reset two cycles after acceptance abandons the operation.
        a = 16'h0777;
        b = 16'h0111;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrun_rst_busy", {31'd0, busy}, 32'd0);
        chk("midrun_rst_diff", {16'd0, diff}, 32'd0);
        chk("midrun_rst_bout", {31'd0, Bout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("midrun_rst_ndone", ndone, 32'd0);
        chk("midrun_rst_diff_hold", {16'd0, diff}, 32'd0);
        run_op(16'h0009, 16'h0002, 16'h0007, 1'b0, "after_rst");

        // Start held high: one result every NIB+2 cycles.
        a = 16'h0003;
        b = 16'h0005;
        start = 1'b1;
        ndone = 0;
        last_done = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (last_done >= 0) chk("stream_period", i - last_done, NIB + 2);
                chk("stream_diff", {16'd0, diff}, 32'h0000FFFE);
                chk("stream_bout", {31'd0, Bout}, 32'd1);
                last_done = i;
            end
        end
        start = 1'b0;
        chk("stream_ndone", ndone, 32'd5);
        for (int i = 0; i < 10; i++) @(negedge clk);
        chk("final_idle", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
